// File: rtl/estacionamiento_pkg.sv
// Shared types and sensor codes for the multi-lane parking controller.
// A sensor code is {beam_a, beam_b}, where 1 means the beam is blocked.
package estacionamiento_pkg;

  typedef enum logic [2:0] {
    IDLE,
    E1,
    E2,
    E3,
    S1,
    S2,
    S3
  } estado_carril_t;

  localparam logic [1:0] S_LIBRE = 2'b00;
  localparam logic [1:0] S_A     = 2'b10;
  localparam logic [1:0] S_B     = 2'b01;
  localparam logic [1:0] S_AB    = 2'b11;

endpackage

// File: rtl/estacionamiento_ctrl_fsm_carril.sv
// One gate lane: A/B beam sequence detector with registered one-cycle
// entry, exit and error pulses.
module fsm_carril
  import estacionamiento_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sensor_a,
  input  logic sensor_b,
  output logic entrada,
  output logic salida,
  output logic error_seq
);

  estado_carril_t estado_reg;
  logic [1:0]     s;

  assign s = {sensor_a, sensor_b};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_reg <= IDLE;
      entrada    <= 1'b0;
      salida     <= 1'b0;
      error_seq  <= 1'b0;
    end else begin
      entrada   <= 1'b0;
      salida    <= 1'b0;
      error_seq <= 1'b0;
      case (estado_reg)
        IDLE: begin
          case (s)
            S_A:     estado_reg <= E1;
            S_B:     estado_reg <= S1;
            S_AB:    error_seq  <= 1'b1;
            default: estado_reg <= IDLE;
          endcase
        end
        E1: begin
          case (s)
            S_AB:    estado_reg <= E2;
            S_LIBRE: estado_reg <= IDLE;
            S_B: begin
              estado_reg <= IDLE;
              error_seq  <= 1'b1;
            end
            default: estado_reg <= E1;
          endcase
        end
        E2: begin
          // Returning to A-only means the car is backing out of the gate.
          case (s)
            S_B:     estado_reg <= E3;
            S_A:     estado_reg <= E1;
            S_LIBRE: begin
              estado_reg <= IDLE;
              error_seq  <= 1'b1;
            end
            default: estado_reg <= E2;
          endcase
        end
        E3: begin
          case (s)
            S_LIBRE: begin
              estado_reg <= IDLE;
              entrada    <= 1'b1;
            end
            S_AB:    estado_reg <= E2;
            S_A: begin
              estado_reg <= IDLE;
              error_seq  <= 1'b1;
            end
            default: estado_reg <= E3;
          endcase
        end
        S1: begin
          case (s)
            S_AB:    estado_reg <= S2;
            S_LIBRE: estado_reg <= IDLE;
            S_A: begin
              estado_reg <= IDLE;
              error_seq  <= 1'b1;
            end
            default: estado_reg <= S1;
          endcase
        end
        S2: begin
          case (s)
            S_A:     estado_reg <= S3;
            S_B:     estado_reg <= S1;
            S_LIBRE: begin
              estado_reg <= IDLE;
              error_seq  <= 1'b1;
            end
            default: estado_reg <= S2;
          endcase
        end
        S3: begin
          case (s)
            S_LIBRE: begin
              estado_reg <= IDLE;
              salida     <= 1'b1;
            end
            S_AB:    estado_reg <= S2;
            S_B: begin
              estado_reg <= IDLE;
              error_seq  <= 1'b1;
            end
            default: estado_reg <= S3;
          endcase
        end
        default: estado_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/estacionamiento_ctrl.sv
// Multi-lane parking controller: per-lane sequence detectors feeding a shared
// occupancy counter with capacity clamping and a sticky overflow flag.
module estacionamiento_ctrl
  import estacionamiento_pkg::*;
#(
  parameter int N_CARRILES = 2,
  parameter int CAPACIDAD  = 7,
  localparam int W = $clog2(CAPACIDAD + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CARRILES-1:0] sensor_a,
  input  logic [N_CARRILES-1:0] sensor_b,
  input  logic                  clr_desborde,
  output logic [N_CARRILES-1:0] entrada,
  output logic [N_CARRILES-1:0] salida,
  output logic [N_CARRILES-1:0] error_seq,
  output logic [W-1:0]          autos,
  output logic                  lleno,
  output logic                  vacio,
  output logic                  desborde
);

  localparam int WS = W + 4;
  localparam logic [WS-1:0] CAP_EXT = WS'(CAPACIDAD);

  logic [W-1:0]  autos_reg;
  logic          desborde_reg;
  logic [WS-1:0] n_e;
  logic [WS-1:0] n_s;
  logic [WS-1:0] suma;
  logic [W-1:0]  autos_next;
  logic          clamp;

  genvar gi;
  generate
    for (gi = 0; gi < N_CARRILES; gi++) begin : g_carril
      fsm_carril u_fsm (
        .clk       (clk),
        .rst       (rst),
        .sensor_a  (sensor_a[gi]),
        .sensor_b  (sensor_b[gi]),
        .entrada   (entrada[gi]),
        .salida    (salida[gi]),
        .error_seq (error_seq[gi])
      );
    end
  endgenerate

  // The sum is kept four bits wider than autos so a negative result shows in the MSB.
  always_comb begin
    n_e = '0;
    n_s = '0;
    for (int i = 0; i < N_CARRILES; i++) begin
      n_e = n_e + WS'(entrada[i]);
      n_s = n_s + WS'(salida[i]);
    end
    suma       = WS'(autos_reg) + n_e - n_s;
    autos_next = suma[W-1:0];
    clamp      = 1'b0;
    if (suma[WS-1]) begin
      autos_next = '0;
      clamp      = 1'b1;
    end else if (suma > CAP_EXT) begin
      autos_next = W'(CAPACIDAD);
      clamp      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      autos_reg    <= '0;
      desborde_reg <= 1'b0;
    end else begin
      autos_reg <= autos_next;
      if (clamp)
        desborde_reg <= 1'b1;
      else if (clr_desborde)
        desborde_reg <= 1'b0;
    end
  end

  assign autos    = autos_reg;
  assign desborde = desborde_reg;
  assign lleno    = (autos_reg == W'(CAPACIDAD));
  assign vacio    = (autos_reg == '0);

endmodule

// File: tb/tb_estacionamiento_ctrl.sv
// Directed bench for estacionamiento_ctrl: a lane-pulse scoreboard plus
// occupancy and flag checks after each scenario.
module tb_estacionamiento_ctrl;

  localparam int N   = 2;
  localparam int CAP = 7;
  localparam int W   = $clog2(CAP + 1);

  typedef struct packed {
    logic [N-1:0] ent;
    logic [N-1:0] sal;
    logic [N-1:0] err;
  } pulso_t;

  logic         clk;
  logic         rst;
  logic [N-1:0] sensor_a;
  logic [N-1:0] sensor_b;
  logic         clr_desborde;
  logic [N-1:0] entrada;
  logic [N-1:0] salida;
  logic [N-1:0] error_seq;
  logic [W-1:0] autos;
  logic         lleno;
  logic         vacio;
  logic         desborde;

  int     n_checks = 0;
  int     n_fail   = 0;
  pulso_t sb[$];
  pulso_t obs_p;
  pulso_t exp_p;

  estacionamiento_ctrl #(.N_CARRILES(N), .CAPACIDAD(CAP)) dut (
    .clk          (clk),
    .rst          (rst),
    .sensor_a     (sensor_a),
    .sensor_b     (sensor_b),
    .clr_desborde (clr_desborde),
    .entrada      (entrada),
    .salida       (salida),
    .error_seq    (error_seq),
    .autos        (autos),
    .lleno        (lleno),
    .vacio        (vacio),
    .desborde     (desborde)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic paso();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [N-1:0] a, input logic [N-1:0] b, input int n);
    sensor_a = a;
    sensor_b = b;
    repeat (n) paso();
  endtask

  // Full pass through the gate: lanes in me enter, lanes in ms exit.
  // Returns right after the edge that samples the final 00.
  task automatic secuencia(input logic [N-1:0] me, input logic [N-1:0] ms);
    pulso_t p;
    apply('0, '0, 2);
    apply(me, ms, 2);
    apply(me | ms, me | ms, 2);
    apply(ms, me, 2);
    p.ent = me;
    p.sal = ms;
    p.err = '0;
    sb.push_back(p);
    apply('0, '0, 1);
  endtask

  // Every observed lane pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst && ((entrada | salida | error_seq) != '0)) begin
      obs_p = {entrada, salida, error_seq};
      if (sb.size() == 0) begin
        chk("pulso_inesperado", 32'(obs_p), 32'd0);
      end else begin
        exp_p = sb.pop_front();
        chk("pulso", 32'(obs_p), 32'(exp_p));
      end
    end
  end

  initial begin
    pulso_t p;
    rst = 1'b1;
    sensor_a = '0;
    sensor_b = '0;
    clr_desborde = 1'b0;
    repeat (2) paso();
    chk("reset_autos", 32'(autos), 32'd0);
    chk("reset_vacio", 32'(vacio), 32'd1);
    chk("reset_lleno", 32'(lleno), 32'd0);
    chk("reset_desborde", 32'(desborde), 32'd0);
    chk("reset_pulsos", 32'({entrada, salida, error_seq}), 32'd0);
    rst = 1'b0;
    paso();

    // Lane 0 entry: pulse at edge N, count one edge later.
    secuencia(2'b01, 2'b00);
    chk("e0_entrada", 32'(entrada), 32'b01);
    chk("e0_autos_antes", 32'(autos), 32'd0);
    paso();
    chk("e0_autos", 32'(autos), 32'd1);
    chk("e0_vacio", 32'(vacio), 32'd0);
    chk("e0_entrada_fin", 32'(entrada), 32'd0);

    // Lane 1 backs out: no pulses, count unchanged.
    apply('0, '0, 2);
    apply(2'b10, '0, 2);
    apply(2'b10, 2'b10, 2);
    apply(2'b10, '0, 2);
    apply('0, '0, 2);
    chk("retroceso_autos", 32'(autos), 32'd1);

    // Fill to capacity with double entries.
    repeat (3) begin
      secuencia(2'b11, 2'b00);
      paso();
    end
    chk("lleno_autos", 32'(autos), 32'd7);
    chk("lleno_flag", 32'(lleno), 32'd1);
    chk("lleno_sin_desborde", 32'(desborde), 32'd0);

    // Entry while full: pulse still emitted, count clamps.
    secuencia(2'b01, 2'b00);
    chk("clamp_entrada", 32'(entrada), 32'b01);
    paso();
    chk("clamp_autos", 32'(autos), 32'd7);
    chk("clamp_desborde", 32'(desborde), 32'd1);
    clr_desborde = 1'b1;
    paso();
    clr_desborde = 1'b0;
    chk("clr_desborde", 32'(desborde), 32'd0);

    // Down to 3 with double exits.
    repeat (2) begin
      secuencia(2'b00, 2'b11);
      paso();
    end
    chk("bajada_autos", 32'(autos), 32'd3);

    // Simultaneous entry on lane 0 and exit on lane 1 cancel out.
    secuencia(2'b01, 2'b10);
    paso();
    chk("mixto_autos", 32'(autos), 32'd3);
    chk("mixto_desborde", 32'(desborde), 32'd0);
    secuencia(2'b11, 2'b00);
    paso();
    chk("doble_autos", 32'(autos), 32'd5);

    // Reset in the middle of a lane 0 entry (state E2).
    apply('0, '0, 2);
    apply(2'b01, '0, 2);
    apply(2'b01, 2'b01, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_autos", 32'(autos), 32'd0);
    chk("rst_async_vacio", 32'(vacio), 32'd1);
    paso();
    rst = 1'b0;
    p.ent = '0;
    p.sal = '0;
    p.err = 2'b01;
    sb.push_back(p);
    paso();
    chk("rst_error_seq", 32'(error_seq), 32'b01);
    apply('0, '0, 2);
    chk("rst_autos", 32'(autos), 32'd0);

    // Exit while empty: pulse emitted, count clamps at zero.
    secuencia(2'b00, 2'b01);
    chk("under_salida", 32'(salida), 32'b01);
    paso();
    chk("under_autos", 32'(autos), 32'd0);
    chk("under_desborde", 32'(desborde), 32'd1);

    apply('0, '0, 2);
    chk("cola_vacia", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/estacionamiento_ctrl.md
# estacionamiento_ctrl

Parametrised multi-lane parking controller, next generation of the single-gate car counter. Each of `N_CARRILES` gates has an A/B beam pair feeding its own entry/exit sequence detector; a shared occupancy counter aggregates all lanes per cycle with capacity clamping, full/empty flags and a sticky overflow flag. Sensor inputs arrive already debounced and synchronous to `clk` (one `antirebote` per sensor, instantiated outside this block).

## Interface
- `N_CARRILES`, default 2: number of gate lanes, 1..8.
- `CAPACIDAD`, default 7: maximum occupancy, at least 1.
- `W`, default $clog2(CAPACIDAD+1): width of `autos` (derived, not overridden).

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `sensor_a`  in  N_CARRILES  beam A per lane, outer side, 1 = blocked.
- `sensor_b`  in  N_CARRILES  beam B per lane, inner side, 1 = blocked.
- `clr_desborde`  in  1  synchronous clear of `desborde`.
- `entrada`  out  N_CARRILES  one-cycle pulse per completed entry.
- `salida`  out  N_CARRILES  one-cycle pulse per completed exit.
- `error_seq`  out  N_CARRILES  one-cycle pulse on an illegal sensor transition.
- `autos`  out  W  current occupancy.
- `lleno`  out  1  high when `autos == CAPACIDAD`.
- `vacio`  out  1  high when `autos == 0`.
- `desborde`  out  1  sticky; set on a clamped update.

## Operation
- Per lane, sensor code s = {a,b}. FSM states: IDLE, E1, E2, E3, S1, S2, S3.
- IDLE: 10→E1; 01→S1; 11→IDLE + `error_seq`; 00 stays.
- E1: 11→E2; 00→IDLE (silent abort); 10 stays; 01→IDLE + error.
- E2: 01→E3; 10→E1 (car backing out); 11 stays; 00→IDLE + error.
- E3: 00→IDLE + `entrada`; 11→E2; 01 stays; 10→IDLE + error.
- S1/S2/S3 mirror E1/E2/E3 with a and b swapped; S3 on 00 → IDLE + `salida`.
- Counter each cycle: n_e = popcount(`entrada`), n_s = popcount(`salida`); next = autos + n_e − n_s, evaluated signed at W+4 bits.
- next > CAPACIDAD → `autos` = CAPACIDAD, `desborde` ← 1. next < 0 → `autos` = 0, `desborde` ← 1. Otherwise `autos` = next.
- Per-lane pulses are emitted even when the count clamps; the gate is not blocked.
- `desborde` holds until `clr_desborde`; if set and clear coincide, set wins.
- `lleno`/`vacio` decode combinationally from the registered `autos`.

## Timing
- Reset (async assert): all FSMs IDLE; `entrada`, `salida`, `error_seq` = 0; `autos` = 0; `desborde` = 0; `vacio` = 1, `lleno` = 0. Synchronous deassert by the surrounding design.
- The final sensor code is sampled at edge N; the `entrada`/`salida`/`error_seq` pulse is registered at edge N and is high for exactly one cycle.
- `autos` updates at edge N+1: one cycle of latency from pulse to count.
- Reset mid-sequence discards partial progress; the first post-reset sample is interpreted from IDLE, so a car already between beams (11) raises `error_seq`.
- Lanes are independent; any combination of lanes may complete in the same cycle.

## Structure
- `estacionamiento_pkg`: state enum `estado_carril_t` (IDLE, E1, E2, E3, S1, S2, S3) and sensor code constants `S_LIBRE`=00, `S_A`=10, `S_B`=01, `S_AB`=11.
- Sub-module `fsm_carril`: one lane FSM with registered `entrada`/`salida`/`error_seq`, instantiated `N_CARRILES` times in a generate loop. Counter, clamp and flags live in the top.

## Test plan
- Lane 0 drives 00,10,11,01,00 (2 cycles each), `autos`=0 → `entrada[0]` single pulse, `autos`=1 one cycle later, `vacio`=0.
- Lane 1 drives 00,10,11,10,00 (back-out) → no pulses, no error, `autos` unchanged.
- CAPACIDAD=7, `autos`=7, lane 0 entry → `entrada[0]` pulses, `autos` stays 7, `lleno`=1, `desborde`=1; then `clr_desborde` → `desborde`=0.
- `autos`=3, lane 0 entry and lane 1 exit completing on the same edge → `autos` stays 3; both lanes entering together → `autos`=5.
- `autos`=0, lane 0 exit (00,01,11,10,00) → `salida[0]` pulses, `autos`=0, `desborde`=1.
- Lane 0 at E2, `rst` asserted mid-cycle → immediate IDLE/zero outputs; after release, hold 11 → `error_seq[0]` pulse, `autos`=0.
